pid_hdng_ctrl: RTL and testbench

Heading PID controller directly downstream of the inertial interface. It consumes each new `heading` sample, qualified by `hdng_vld` (the interface's `rdy`), and compares it against a commanded heading. It produces registered left/right motor speed commands and an `at_hdng` flag for the navigation logic.

---
 rtl/pid_hdng_ctrl.sv | 94 +++++++++
 tb/tb_pid_hdng_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pid_hdng_ctrl.sv
// pid_hdng_ctrl: two-stage heading PID producing saturated left/right motor speed commands
module pid_hdng_ctrl #(
   parameter logic [3:0] P_COEFF  = 4'd3,
   parameter logic [4:0] D_COEFF  = 5'd5,
   parameter int         HDNG_TOL = 30
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               moving,
   input  logic               hdng_vld,
   input  logic signed [11:0] heading,
   input  logic signed [11:0] dsrd_hdng,
   input  logic        [10:0] frwrd_spd,
   output logic signed [11:0] lft_spd,
   output logic signed [11:0] rght_spd,
   output logic               spd_vld,
   output logic               at_hdng
);
   logic signed [12:0] err;
   logic signed [9:0]  err_sat;
   logic signed [9:0]  err_sat_q;
   logic signed [9:0]  prev_err;
   logic               vld1;
   logic signed [15:0] integ;
   logic signed [15:0] integ_sum;
   logic               ovf;
   logic signed [10:0] diff;
   logic signed [10:0] abs_err;
   logic signed [7:0]  diff_sat;
   logic signed [13:0] p_term;
   logic signed [13:0] i_term;
   logic signed [13:0] d_term;
   logic signed [14:0] sum;
   logic signed [11:0] steer;
   logic signed [12:0] lft_raw;
   logic signed [12:0] rght_raw;
   logic signed [11:0] lft_nxt;
   logic signed [11:0] rght_nxt;

   assign err       = 13'(heading) - 13'(dsrd_hdng);
   assign err_sat   = (err > 13'sd511) ? 10'h1FF : (err < -13'sd512) ? 10'h200 : err[9:0];
   assign p_term    = 14'(err_sat_q) * $signed({10'd0, P_COEFF});
   assign i_term    = 14'($signed(integ[15:4]));
   assign diff      = 11'(err_sat_q) - 11'(prev_err);
   assign diff_sat  = (diff > 11'sd127) ? 8'h7F : (diff < -11'sd128) ? 8'h80 : diff[7:0];
   assign d_term    = 14'(diff_sat) * $signed({9'd0, D_COEFF});
   assign sum       = 15'(p_term) + 15'(i_term) + 15'(d_term);
   // floor of sum / 8 is just the upper bits of the two's-complement sum
   assign steer     = sum[14:3];
   assign lft_raw   = $signed({2'b00, frwrd_spd}) + 13'(steer);
   assign rght_raw  = $signed({2'b00, frwrd_spd}) - 13'(steer);
   assign lft_nxt   = (lft_raw > 13'sd2047) ? 12'h7FF : (lft_raw < -13'sd2048) ? 12'h800 : lft_raw[11:0];
   assign rght_nxt  = (rght_raw > 13'sd2047) ? 12'h7FF : (rght_raw < -13'sd2048) ? 12'h800 : rght_raw[11:0];
   assign integ_sum = integ + 16'(err_sat_q);
   assign ovf       = (integ[15] == err_sat_q[9]) && (integ_sum[15] != integ[15]);
   assign abs_err   = err_sat_q[9] ? -11'(err_sat_q) : 11'(err_sat_q);

   // stage 1: capture the saturated error of each new heading sample
   always_ff @(posedge clk) begin
      if (rst) begin
         vld1      <= 1'b0;
         err_sat_q <= '0;
      end else begin
         vld1 <= hdng_vld;
         if (hdng_vld) err_sat_q <= err_sat;
      end
   end

   // stage 2: apply PID terms, update controller state; standing still clears everything
   always_ff @(posedge clk) begin
      if (rst) begin
         spd_vld  <= 1'b0;
         at_hdng  <= 1'b0;
         integ    <= '0;
         prev_err <= '0;
         lft_spd  <= '0;
         rght_spd <= '0;
      end else begin
         spd_vld <= vld1;
         if (vld1) at_hdng <= int'(abs_err) < HDNG_TOL;
         if (!moving) begin
            integ    <= '0;
            prev_err <= '0;
            lft_spd  <= '0;
            rght_spd <= '0;
         end else if (vld1) begin
            integ    <= ovf ? integ : integ_sum;
            prev_err <= err_sat_q;
            lft_spd  <= lft_nxt;
            rght_spd <= rght_nxt;
         end
      end
   end
endmodule

// File: tb/tb_pid_hdng_ctrl.sv
// tb_pid_hdng_ctrl: directed vectors checked against an integer behavioural model every cycle
module tb_pid_hdng_ctrl;
   logic               clk;
   logic               rst;
   logic               moving;
   logic               hdng_vld;
   logic signed [11:0] heading;
   logic signed [11:0] dsrd_hdng;
   logic        [10:0] frwrd_spd;
   logic signed [11:0] lft_spd;
   logic signed [11:0] rght_spd;
   logic               spd_vld;
   logic               at_hdng;

   int vectors = 0;
   int miscompares = 0;
   bit chk_on = 0;

   int m_p1, m_q, m_integ, m_prev, m_lft, m_rght, m_vld, m_at;

   pid_hdng_ctrl dut (
      .clk(clk), .rst(rst), .moving(moving), .hdng_vld(hdng_vld),
      .heading(heading), .dsrd_hdng(dsrd_hdng), .frwrd_spd(frwrd_spd),
      .lft_spd(lft_spd), .rght_spd(rght_spd), .spd_vld(spd_vld), .at_hdng(at_hdng)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   function automatic int clamp(int v, int lo, int hi);
      return v < lo ? lo : v > hi ? hi : v;
   endfunction

   task automatic chk(string name, int act, int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // reference model: each accepted sample is turned into speeds one edge after capture
   always @(posedge clk) begin
      int p, i, d, st, ns;
      if (rst) begin
         m_p1 = 0; m_q = 0; m_integ = 0; m_prev = 0;
         m_lft = 0; m_rght = 0; m_vld = 0; m_at = 0;
      end else begin
         m_vld = m_p1;
         if (m_p1) begin
            p = m_q * 3;
            i = m_integ >>> 4;
            d = clamp(m_q - m_prev, -128, 127) * 5;
            st = (p + i + d) >>> 3;
            m_at = ((m_q < 0) ? -m_q : m_q) < 30;
            if (moving) begin
               m_lft = clamp(int'(frwrd_spd) + st, -2048, 2047);
               m_rght = clamp(int'(frwrd_spd) - st, -2048, 2047);
               ns = m_integ + m_q;
               if (ns >= -32768 && ns <= 32767) m_integ = ns;
               m_prev = m_q;
            end
         end
         if (!moving) begin
            m_integ = 0; m_prev = 0; m_lft = 0; m_rght = 0;
         end
         m_p1 = hdng_vld;
         if (hdng_vld) m_q = clamp(int'(heading) - int'(dsrd_hdng), -512, 511);
      end
   end

   // per-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_on) begin
         chk("lft_spd", int'(lft_spd), m_lft);
         chk("rght_spd", int'(rght_spd), m_rght);
         chk("spd_vld", int'(spd_vld), m_vld);
         chk("at_hdng", int'(at_hdng), m_at);
      end
   end

   task automatic do_reset();
      rst = 1;
      @(negedge clk);
      @(negedge clk);
      rst = 0;
   endtask

   // called at a negedge; returns at the negedge where the resulting spd_vld is visible
   task automatic strobe(int h, int dh);
      heading = 12'(h);
      dsrd_hdng = 12'(dh);
      hdng_vld = 1;
      @(negedge clk);
      hdng_vld = 0;
      @(negedge clk);
   endtask

   task automatic lit(string name, int l, int r, int at);
      chk({name, "_lft"}, int'(lft_spd), l);
      chk({name, "_rght"}, int'(rght_spd), r);
      chk({name, "_vld"}, int'(spd_vld), 1);
      chk({name, "_at"}, int'(at_hdng), at);
   endtask

   initial begin
      rst = 1; moving = 0; hdng_vld = 0; heading = 0; dsrd_hdng = 0; frwrd_spd = 0;
      @(negedge clk);
      chk_on = 1;
      for (int k = 0; k < 4; k++) begin
         hdng_vld = ~hdng_vld;
         heading = 12'(100 * k);
         @(negedge clk);
      end
      rst = 0;
      hdng_vld = 0;
      @(negedge clk);
      chk("rst_lft", int'(lft_spd), 0);
      chk("rst_rght", int'(rght_spd), 0);
      chk("rst_vld", int'(spd_vld), 0);
      chk("rst_at", int'(at_hdng), 0);

      moving = 1;
      frwrd_spd = 11'd512;
      strobe(100, 0);
      lit("first", 612, 412, 0);
      @(negedge clk);
      chk("first_pulse_end", int'(spd_vld), 0);
      strobe(100, 0);
      lit("second", 550, 474, 0);

      do_reset();
      strobe(2047, -2048);
      lit("sat", 783, 241, 0);

      strobe(20, 0);
      chk("tol_in", int'(at_hdng), 1);
      strobe(-30, 0);
      chk("tol_edge", int'(at_hdng), 0);
      strobe(29, 0);
      chk("tol_29", int'(at_hdng), 1);

      do_reset();
      heading = 12'sd2047;
      dsrd_hdng = -12'sd2048;
      hdng_vld = 1;
      repeat (65) @(negedge clk);
      strobe(0, 0);
      lit("integ_cap", 687, 337, 1);

      moving = 0;
      @(negedge clk);
      chk("stop_lft", int'(lft_spd), 0);
      chk("stop_rght", int'(rght_spd), 0);
      moving = 1;
      @(negedge clk);
      strobe(100, 0);
      lit("after_stop", 612, 412, 0);

      heading = 12'sd300;
      hdng_vld = 1;
      @(negedge clk);
      hdng_vld = 0;
      rst = 1;
      @(negedge clk);
      rst = 0;
      repeat (3) begin
         @(negedge clk);
         chk("flushed_vld", int'(spd_vld), 0);
      end
      strobe(100, 0);
      lit("post_rst", 612, 412, 0);
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
